// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: runtime preset selection and lock supervision for a Gowin rPLL
// driven through its dynamic IDSEL/FBDSEL/ODSEL ports. Each applied preset gets
// a timed PLL reset, a bounded wait for LOCK, a stability qualification window,
// and a limited number of retries before the controller gives up.
module pll_dyn_ctrl #(
  parameter int unsigned           NUM_MODES    = 4,
  // Entry m = {idsel, fbdsel, odsel}; entry 0 at the LSBs.
  parameter logic [NUM_MODES*18-1:0] CFG_TABLE  = {
    {6'd61, 6'd47, 6'd60},
    {6'd62, 6'd53, 6'd56},
    {6'd63, 6'd52, 6'd56},
    {6'd63, 6'd41, 6'd60}
  },
  parameter int unsigned           DEFAULT_MODE = 0,
  parameter int unsigned           RST_CYCLES   = 16,
  parameter int unsigned           LOCK_TIMEOUT = 65535,
  parameter int unsigned           LOCK_STABLE  = 1024,
  parameter int unsigned           MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode_sel,
  input  logic       mode_req,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic [2:0] cur_mode,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic       req_err,
  output logic       pix_rst_n
);

  localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]   RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(LOCK_STABLE - 1);
  localparam logic [17:0]        DEFAULT_CFG = CFG_TABLE[18*DEFAULT_MODE +: 18];

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [2:0]          mode_d;
  logic [17:0]         cfg_q, cfg_d;
  logic                req_valid;
  logic                req_err_d;
  logic                lock_m, lock_s;
  logic [17:0]         cfg_rom [8];

  // Preset lookup padded to the full 3-bit selector range; unused slots read zero.
  for (genvar g = 0; g < 8; g++) begin : g_rom
    if (g < NUM_MODES) begin : g_used
      assign cfg_rom[g] = CFG_TABLE[18*g +: 18];
    end else begin : g_unused
      assign cfg_rom[g] = '0;
    end
  end

  assign idsel  = cfg_q[17:12];
  assign fbdsel = cfg_q[11:6];
  assign odsel  = cfg_q[5:0];

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Next-state, counter and preset selection; a valid request overrides every state.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    stab_cnt_d = stab_cnt_q;
    retry_d    = retry_q;
    mode_d     = cur_mode;
    cfg_d      = cfg_q;
    req_valid  = mode_req && (32'(mode_sel) < NUM_MODES);
    req_err_d  = mode_req && !req_valid;

    if (req_valid) begin
      state_d    = S_RESET;
      mode_d     = mode_sel;
      cfg_d      = cfg_rom[mode_sel];
      rst_cnt_d  = '0;
      to_cnt_d   = '0;
      stab_cnt_d = '0;
      retry_d    = '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          to_cnt_d   = '0;
          stab_cnt_d = '0;
          if (rst_cnt_q >= RST_LAST) begin
            state_d = S_WAIT_LOCK;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d    = S_STABLE;
            stab_cnt_d = STAB_W'(1);
          end else if (to_cnt_q >= TO_LAST) begin
            if (32'(retry_q) < MAX_RETRY) begin
              retry_d = retry_q + RETRY_W'(1);
            end
            rst_cnt_d = '0;
            if (32'(retry_q) + 32'd1 < MAX_RETRY) begin
              state_d = S_RESET;
            end else begin
              state_d = S_FAIL;
            end
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_STABLE: begin
          // Dropping back keeps the timeout count so glitchy locks still time out.
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
          end else if (stab_cnt_q >= STAB_LAST) begin
            state_d = S_LOCKED;
          end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
          end
        end
        S_LOCKED: begin
          if (!lock_s) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            retry_d   = '0;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // State, counters and all status outputs registered from the next state so none glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stab_cnt_q <= '0;
      retry_q    <= '0;
      cur_mode   <= 3'(DEFAULT_MODE);
      cfg_q      <= DEFAULT_CFG;
      pll_reset  <= 1'b1;
      locked     <= 1'b0;
      busy       <= 1'b1;
      fail       <= 1'b0;
      req_err    <= 1'b0;
      pix_rst_n  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      retry_q    <= retry_d;
      cur_mode   <= mode_d;
      cfg_q      <= cfg_d;
      pll_reset  <= (state_d == S_RESET);
      locked     <= (state_d == S_LOCKED);
      busy       <= (state_d == S_RESET) || (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
      fail       <= (state_d == S_FAIL);
      req_err    <= req_err_d;
      pix_rst_n  <= (state_d == S_LOCKED);
    end
  end

endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 4: number of PLL divider presets, legal 1..8.
REQ-002 SHALL have parameter CFG_TABLE, default 4 presets: packed NUM_MODES x 18 bits; entry m = {idsel[5:0], fbdsel[5:0], odsel[5:0]} rPLL dynamic-port codes; entry 0 at LSBs.
REQ-003 SHALL have parameter DEFAULT_MODE, default 0: preset applied after reset.
REQ-004 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse width in clk cycles, >=2.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed for lock per attempt.
REQ-006 SHALL have parameter LOCK_STABLE, default 1024: consecutive locked cycles before declaring lock.
REQ-007 SHALL have parameter MAX_RETRY, default 3: attempts per configuration before failure.
REQ-008 SHALL have port clk  input  1  reference clock (27 MHz crystal); all logic on rising edge.
REQ-009 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-010 SHALL have port mode_sel  input  3  requested preset index.
REQ-011 SHALL have port mode_req  input  1  one-cycle request strobe; samples mode_sel.
REQ-012 SHALL have port pll_lock  input  1  rPLL LOCK, asynchronous to clk.
REQ-013 SHALL have port pll_reset  output  1  drives rPLL RESET.
REQ-014 SHALL have ports idsel, fbdsel, odsel  output  6 each  drive rPLL IDSEL/FBDSEL/ODSEL.
REQ-015 SHALL have port cur_mode  output  3  preset currently applied.
REQ-016 SHALL have ports locked, busy, fail, req_err  output  1 each  status; req_err is a one-cycle pulse.
REQ-017 SHALL have port pix_rst_n  output  1  active-low reset for downstream pixel/TMDS logic.

Function
REQ-018 SHALL pass pll_lock through a 2-flop synchroniser (lock_s); all lock decisions use lock_s.
REQ-019 SHALL implement FSM states RESET, WAIT_LOCK, STABLE, LOCKED, FAIL.
REQ-020 SHALL hold pll_reset=1 in RESET only; dividers and cur_mode SHALL change only on the cycle entering RESET.
REQ-021 RESET: after exactly RST_CYCLES cycles -> WAIT_LOCK; timer cleared on entry.
REQ-022 WAIT_LOCK: lock_s=1 -> STABLE; timer reaching LOCK_TIMEOUT -> retry+1; if retry < MAX_RETRY -> RESET (same preset), else -> FAIL.
REQ-023 STABLE: LOCK_STABLE consecutive lock_s=1 cycles -> LOCKED; any lock_s=0 -> WAIT_LOCK with timeout timer preserved (not cleared).
REQ-024 LOCKED: locked=1, pix_rst_n=1; lock_s=0 -> locked=0 and pix_rst_n=0 same cycle as the transition, retry cleared, -> RESET same preset.
REQ-025 FAIL: fail=1, pll_reset=0, locked=0, pix_rst_n=0; remains until valid mode_req or rst_n.
REQ-026 busy SHALL be 1 in RESET, WAIT_LOCK, STABLE; 0 in LOCKED and FAIL.
REQ-027 Valid mode_req (mode_sel < NUM_MODES) in any state SHALL load the preset, clear retry and fail, force locked=0, pix_rst_n=0, and enter RESET next cycle, restarting an in-progress RESET count.
REQ-028 mode_req with mode_sel >= NUM_MODES SHALL be ignored except req_err=1 for one cycle.
REQ-029 Valid mode_req and lock loss in the same cycle: mode_req wins (new preset applied).
REQ-030 Counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter.
REQ-031 pix_rst_n SHALL assert (go low) combinationally-free: registered, never glitching; deassert only after LOCKED entry.

Reset
REQ-032 rst_n=0 SHALL yield next edge: state RESET, pll_reset=1, dividers and cur_mode = DEFAULT_MODE entry, locked=0, busy=1, fail=0, req_err=0, pix_rst_n=0, retry=0, timers=0, synchroniser=0.
REQ-033 rst_n asserted mid-operation (any state) SHALL override all inputs, including a coincident mode_req.

Verification (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2, NUM_MODES=4)
REQ-034 Release reset, pll_lock=1 from cycle 10 -> pll_reset high exactly 4 cycles, locked=1 and pix_rst_n=1 exactly 8 cycles after lock_s rises.
REQ-035 pll_lock held 0 -> two 4-cycle pll_reset pulses 100 cycles apart, then fail=1, busy=0, pll_reset=0; then mode_req mode_sel=2 -> fail=0, dividers=entry 2, new RESET.
REQ-036 LOCKED, pll_lock drops 1 cycle -> locked=0, pix_rst_n=0, fresh 4-cycle pll_reset, relock on same preset.
REQ-037 Lock glitches low at stable count 5 -> back to WAIT_LOCK, count restarts; locked only after 8 uninterrupted cycles.
REQ-038 mode_req mode_sel=5 while LOCKED -> req_err single pulse, locked stays 1, dividers unchanged; mode_req mode_sel=1 during RESET cycle 2 -> RESET restarts, 4 full cycles with entry 1.
